// File: rtl/load_store_unit_if.sv
// Bundles the core request, data-memory and writeback response signals of the load/store unit.
// The master drives requests and memory responses; the slave is the unit itself.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: traps bad accesses, runs one valid/ready memory transaction,
// and returns the lane-extracted load value or a store completion pulse.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic              clk_i,
    input logic              rst_i,
    load_store_unit_if.slave lsu_io
);

    localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic [15:0] wait_q, wait_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    logic [2:0]  req_f3;
    logic [1:0]  req_off;
    logic        req_illegal;
    logic        req_misaligned;
    logic        req_error;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] rdata_shift;
    logic [31:0] load_data;

    // Request decode: legality, alignment and store lane placement
    always_comb begin
        req_f3         = lsu_io.req_funct3;
        req_off        = lsu_io.req_addr[1:0];
        req_illegal    = (req_f3 == 3'b011) || (req_f3 == 3'b110) || (req_f3 == 3'b111) ||
                         (lsu_io.req_store && req_f3[2]);
        req_misaligned = ((req_f3[1:0] == 2'b01) && req_off[0]) ||
                         ((req_f3[1:0] == 2'b10) && (req_off != 2'b00));
        req_error      = req_illegal || req_misaligned;

        lane_wdata = lsu_io.req_wdata;
        lane_wstrb = 4'b1111;
        case (req_f3[1:0])
            2'b00: begin
                lane_wdata = {4{lsu_io.req_wdata[7:0]}};
                lane_wstrb = 4'b0001 << req_off;
            end
            2'b01: begin
                lane_wdata = {2{lsu_io.req_wdata[15:0]}};
                lane_wstrb = req_off[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (!lsu_io.req_store) begin
            lane_wstrb = 4'b0000;
        end
    end

    // Load extraction from the word currently on mem_rdata
    always_comb begin
        rdata_shift = lsu_io.mem_rdata >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_data = {24'd0, rdata_shift[7:0]};
            3'b101:  load_data = {16'd0, rdata_shift[15:0]};
            default: load_data = rdata_shift;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        wait_d       = wait_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        // Response outputs only live for the single RESP cycle
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_error_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (lsu_io.req_valid) begin
                    store_d     = lsu_io.req_store;
                    funct3_d    = req_f3;
                    offset_d    = req_off;
                    wait_d      = 16'd0;
                    mem_addr_d  = {lsu_io.req_addr[31:2], 2'b00};
                    mem_wdata_d = lane_wdata;
                    if (req_error) begin
                        state_d      = StResp;
                        mem_wstrb_d  = 4'b0000;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else begin
                        state_d     = StReq;
                        mem_wstrb_d = lane_wstrb;
                        mem_valid_d = 1'b1;
                    end
                end
            end
            StReq: begin
                if (lsu_io.mem_ready) begin
                    state_d      = StResp;
                    mem_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = store_q ? 32'd0 : load_data;
                end else if (wait_q == TimeoutLimit) begin
                    state_d      = StResp;
                    mem_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d     = StIdle;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            store_q      <= 1'b0;
            funct3_q     <= 3'd0;
            offset_q     <= 2'd0;
            wait_q       <= 16'd0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_wstrb_q  <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            offset_q     <= offset_d;
            wait_q       <= wait_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign lsu_io.req_ready  = (state_q == StIdle);
    assign lsu_io.mem_valid  = mem_valid_q;
    assign lsu_io.mem_addr   = mem_addr_q;
    assign lsu_io.mem_wdata  = mem_wdata_q;
    assign lsu_io.mem_wstrb  = mem_wstrb_q;
    assign lsu_io.resp_valid = resp_valid_q;
    assign lsu_io.resp_rdata = resp_rdata_q;
    assign lsu_io.resp_error = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected responses are queued as each access is issued
// and compared when the unit pulses resp_valid; the bench also plays the data memory.
module tb_load_store_unit;

    localparam int unsigned T = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  wstrb;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .lsu_io (bus)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    int          o_lat, o_wait;
    logic        o_saw, o_stable, o_mv_resp, o_err;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_wstrb;

    // Present a request and return just after the accepting edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, wd);
        bit done = 0;
        bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        o_wait = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            o_wait++;
            if (bus.req_ready) begin
                @(posedge clk);
                done = 1;
            end
        end
        #1 bus.req_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_bound: req_ready never seen in 20 cycles");
        end
    endtask

    // Act as memory: mem_ready low for 'delay' REQ cycles, then high; capture the response.
    task automatic run_mem(input int delay, input logic [31:0] rd);
        bit got = 0;
        o_saw = 0; o_stable = 1; o_lat = 0; o_mv_resp = 0; o_err = 0; o_rdata = '0;
        bus.mem_rdata = rd;
        bus.mem_ready = (delay == 0);
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(negedge clk);
            if (bus.mem_valid) begin
                if (!o_saw) begin
                    o_addr = bus.mem_addr; o_wdata = bus.mem_wdata; o_wstrb = bus.mem_wstrb;
                    o_saw = 1;
                end else if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
                             {o_addr, o_wdata, o_wstrb}) begin
                    o_stable = 0;
                end
            end
            if (bus.resp_valid) begin
                got = 1; o_lat = cyc; o_rdata = bus.resp_rdata; o_err = bus.resp_error;
                o_mv_resp = bus.mem_valid;
            end else begin
                @(posedge clk);
                #1 bus.mem_ready = (cyc + 1 > delay);
            end
        end
        bus.mem_ready = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL resp_bound: no resp_valid within 40 cycles");
        end
    endtask

    function automatic exp_t model(input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr, wdata, rdata, input int delay);
        exp_t e;
        int   idx = int'(addr[1:0]);
        logic bad;
        logic [7:0]  b;
        logic [15:0] h;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]) ||
              ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) || (f3 == 3'b010 && addr[1:0] != 0);
        e.addr = addr & 32'hFFFF_FFFC; e.wdata = wdata; e.rdata = '0; e.wstrb = '0;
        e.err = bad; e.lat = 1;
        if (bad) return e;
        if (delay >= int'(T) + 1) begin
            e.err = 1; e.lat = int'(T) + 2;
        end else begin
            e.lat = delay + 2;
        end
        if (st) begin
            case (f3)
                3'b000: begin e.wdata = {4{wdata[7:0]}}; e.wstrb = 4'(1 << idx); end
                3'b001: begin e.wdata = {2{wdata[15:0]}};
                              e.wstrb = (idx >= 2) ? 4'b1100 : 4'b0011; end
                default: e.wstrb = 4'b1111;
            endcase
        end else if (!e.err) begin
            b = rdata[idx*8 +: 8];
            h = (idx >= 2) ? rdata[31:16] : rdata[15:0];
            case (f3)
                3'b000: e.rdata = {{24{b[7]}}, b};
                3'b001: e.rdata = {{16{h[15]}}, h};
                3'b100: e.rdata = {24'd0, b};
                3'b101: e.rdata = {16'd0, h};
                default: e.rdata = rdata;
            endcase
        end
        return e;
    endfunction

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks += 8;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b want 0", bus.mem_valid); end
        if (bus.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        if (bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        if (bus.mem_wstrb !== 4'd0) begin errors++; $display("FAIL reset_mem_wstrb: got %b want 0", bus.mem_wstrb); end
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
        if (bus.resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); end
        if (bus.resp_error !== 1'b0) begin errors++; $display("FAIL reset_resp_error: got %b want 0", bus.resp_error); end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s  [6];
        logic [31:0] adrs [6];
        logic [31:0] rds  [6];
        logic [31:0] exps [6];
        exp_t e;
        f3s  = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        adrs = '{32'h104, 32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
        rds  = '{32'hDEADBEEF, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h0000007F};
        exps = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h0000007F};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{addr: adrs[i] & 32'hFFFFFFFC, wdata: '0, rdata: exps[i],
                              wstrb: 4'b0000, err: 1'b0, lat: 2});
            issue(1'b0, f3s[i], adrs[i], 32'hFFFF_FFFF);
            run_mem(0, rds[i]);
            e = exp_q.pop_front();
            checks += 5;
            if (o_addr !== e.addr) begin errors++; $display("FAIL load%0d_addr: got %h want %h", i, o_addr, e.addr); end
            if (o_wstrb !== e.wstrb) begin errors++; $display("FAIL load%0d_wstrb: got %b want %b", i, o_wstrb, e.wstrb); end
            if (o_rdata !== e.rdata) begin errors++; $display("FAIL load%0d_rdata: got %h want %h", i, o_rdata, e.rdata); end
            if (o_err !== e.err) begin errors++; $display("FAIL load%0d_err: got %b want %b", i, o_err, e.err); end
            if (o_lat !== e.lat) begin errors++; $display("FAIL load%0d_latency: got %0d want %0d", i, o_lat, e.lat); end
        end
        @(negedge clk);
        checks += 2;
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL resp_pulse_width: resp_valid %b want 0", bus.resp_valid); end
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_after_resp: req_ready %b want 1", bus.req_ready); end
    endtask

    task automatic test_stores;
        logic [2:0]  f3s  [4];
        logic [31:0] adrs [4];
        logic [31:0] wds  [4];
        logic [31:0] ewd  [4];
        logic [3:0]  ews  [4];
        exp_t e;
        f3s  = '{3'b000, 3'b001, 3'b010, 3'b000};
        adrs = '{32'h202, 32'h202, 32'hFFFFFFFC, 32'h201};
        wds  = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h000000AB};
        ewd  = '{32'h78787878, 32'h56785678, 32'h12345678, 32'hABABABAB};
        ews  = '{4'b0100, 4'b1100, 4'b1111, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{addr: adrs[i] & 32'hFFFFFFFC, wdata: ewd[i], rdata: '0,
                              wstrb: ews[i], err: 1'b0, lat: 2});
            issue(1'b1, f3s[i], adrs[i], wds[i]);
            run_mem(0, 32'hFFFF_FFFF);
            e = exp_q.pop_front();
            checks += 6;
            if (o_addr !== e.addr) begin errors++; $display("FAIL store%0d_addr: got %h want %h", i, o_addr, e.addr); end
            if (o_wdata !== e.wdata) begin errors++; $display("FAIL store%0d_wdata: got %h want %h", i, o_wdata, e.wdata); end
            if (o_wstrb !== e.wstrb) begin errors++; $display("FAIL store%0d_wstrb: got %b want %b", i, o_wstrb, e.wstrb); end
            if (o_rdata !== e.rdata) begin errors++; $display("FAIL store%0d_rdata: got %h want %h", i, o_rdata, e.rdata); end
            if (o_err !== e.err) begin errors++; $display("FAIL store%0d_err: got %b want %b", i, o_err, e.err); end
            if (o_lat !== e.lat) begin errors++; $display("FAIL store%0d_latency: got %0d want %0d", i, o_lat, e.lat); end
        end
    endtask

    task automatic test_errors;
        logic        sts  [5];
        logic [2:0]  f3s  [5];
        logic [31:0] adrs [5];
        exp_t e;
        sts  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        f3s  = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b111};
        adrs = '{32'h101, 32'h3, 32'h0, 32'h0, 32'h40};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{addr: '0, wdata: '0, rdata: '0, wstrb: '0, err: 1'b1, lat: 1});
            issue(sts[i], f3s[i], adrs[i], 32'hA5A5_A5A5);
            run_mem(0, 32'hFFFF_FFFF);
            e = exp_q.pop_front();
            checks += 4;
            if (o_saw !== 1'b0) begin errors++; $display("FAIL err%0d_mem_valid: mem_valid seen %b want 0", i, o_saw); end
            if (o_lat !== e.lat) begin errors++; $display("FAIL err%0d_latency: got %0d want %0d", i, o_lat, e.lat); end
            if (o_err !== e.err) begin errors++; $display("FAIL err%0d_error: got %b want %b", i, o_err, e.err); end
            if (o_rdata !== e.rdata) begin errors++; $display("FAIL err%0d_rdata: got %h want %h", i, o_rdata, e.rdata); end
        end
    endtask

    task automatic test_wait_states;
        exp_t e;
        exp_q.push_back('{addr: 32'h104, wdata: '0, rdata: 32'h11223344, wstrb: '0, err: 1'b0, lat: 5});
        issue(1'b0, 3'b010, 32'h104, 32'h0);
        run_mem(3, 32'h11223344);
        e = exp_q.pop_front();
        checks += 4;
        if (o_stable !== 1'b1) begin errors++; $display("FAIL wait_stable: outputs changed during REQ"); end
        if (o_lat !== e.lat) begin errors++; $display("FAIL wait_latency: got %0d want %0d", o_lat, e.lat); end
        if (o_rdata !== e.rdata) begin errors++; $display("FAIL wait_rdata: got %h want %h", o_rdata, e.rdata); end
        if (o_err !== e.err) begin errors++; $display("FAIL wait_err: got %b want %b", o_err, e.err); end
    endtask

    task automatic test_timeout;
        exp_t e;
        exp_q.push_back('{addr: 32'h108, wdata: '0, rdata: '0, wstrb: '0, err: 1'b1, lat: int'(T) + 2});
        issue(1'b0, 3'b010, 32'h108, 32'h0);
        run_mem(1000, 32'h55AA55AA);
        e = exp_q.pop_front();
        checks += 5;
        if (o_saw !== 1'b1) begin errors++; $display("FAIL timeout_mem_valid: seen %b want 1", o_saw); end
        if (o_lat !== e.lat) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", o_lat, e.lat); end
        if (o_err !== e.err) begin errors++; $display("FAIL timeout_err: got %b want %b", o_err, e.err); end
        if (o_rdata !== e.rdata) begin errors++; $display("FAIL timeout_rdata: got %h want %h", o_rdata, e.rdata); end
        if (o_mv_resp !== 1'b0) begin errors++; $display("FAIL timeout_mem_drop: mem_valid %b want 0", o_mv_resp); end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        issue(1'b0, 3'b010, 32'h110, 32'h0);
        bus.mem_ready = 1'b0;
        #2;
        checks++;
        if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: mem_valid %b want 1", bus.mem_valid); end
        rst = 1'b1;
        #1;
        checks += 2;
        if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL midrst_async: mem_valid %b want 0", bus.mem_valid); end
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: req_ready %b want 1", bus.req_ready); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{addr: 32'h114, wdata: '0, rdata: 32'hCAFEF00D, wstrb: '0, err: 1'b0, lat: 2});
        issue(1'b0, 3'b010, 32'h114, 32'h0);
        run_mem(0, 32'hCAFEF00D);
        e = exp_q.pop_front();
        checks += 3;
        if (o_lat !== e.lat) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", o_lat, e.lat); end
        if (o_rdata !== e.rdata) begin errors++; $display("FAIL midrst_rdata: got %h want %h", o_rdata, e.rdata); end
        if (o_err !== e.err) begin errors++; $display("FAIL midrst_err: got %b want %b", o_err, e.err); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic st;
        logic [2:0] f3;
        logic [31:0] a, wd, rd;
        int dly;
        logic [2:0] ld_f3 [5];
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 12; i++) begin
            st  = 1'(($urandom >> 3) & 1);
            f3  = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            a   = 32'h3000 + ($urandom & 32'hFF);
            wd  = $urandom;
            rd  = $urandom;
            dly = $urandom_range(0, 2);
            exp_q.push_back(model(st, f3, a, wd, rd, dly));
            issue(st, f3, a, wd);
            run_mem(dly, rd);
            e = exp_q.pop_front();
            checks += 5;
            if (i > 0 && o_wait !== 1) begin errors++; $display("FAIL b2b%0d_accept: waited %0d want 1", i, o_wait); end
            if (o_lat !== e.lat) begin errors++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, o_lat, e.lat); end
            if (o_err !== e.err) begin errors++; $display("FAIL b2b%0d_err: got %b want %b", i, o_err, e.err); end
            if (o_rdata !== e.rdata) begin errors++; $display("FAIL b2b%0d_rdata: got %h want %h", i, o_rdata, e.rdata); end
            if (o_saw !== (e.lat != 1)) begin errors++; $display("FAIL b2b%0d_mem_valid: seen %b", i, o_saw); end
            if (o_saw) begin
                checks += 2;
                if (o_addr !== e.addr) begin errors++; $display("FAIL b2b%0d_addr: got %h want %h", i, o_addr, e.addr); end
                if (o_wstrb !== e.wstrb) begin errors++; $display("FAIL b2b%0d_wstrb: got %b want %b", i, o_wstrb, e.wstrb); end
                if (st) begin
                    checks++;
                    if (o_wdata !== e.wdata) begin errors++; $display("FAIL b2b%0d_wdata: got %h want %h", i, o_wdata, e.wdata); end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit for the lab4 lw/sw datapath. It sits directly downstream of the ALU: it takes the ALU result as the effective address, together with rs2 store data and the instruction funct3. It runs one data-memory transaction over a valid/ready handshake and returns the sign- or zero-extended load value, or a completion pulse for stores, to writeback. Misaligned or illegal accesses are trapped before any memory traffic.

## Interface
- TIMEOUT_CYCLES, 255: number of consecutive REQ cycles with mem_ready low before the access is aborted with an error. Legal range 1..65535.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces IDLE
- req_valid  in  1  core presents an access
- req_ready  out  1  unit can accept an access (high only in IDLE)
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  store data (rs2)
- mem_valid  out  1  memory request active
- mem_ready  in  1  memory accepts/completes this cycle
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_wdata  out  32  lane-positioned store data
- mem_wstrb  out  4  byte enables; 4'b0000 for loads
- mem_rdata  in  32  read word, valid when mem_valid && mem_ready
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned, illegal funct3, or timeout; valid with resp_valid

## Operation
- States: IDLE, REQ, RESP.
- IDLE: req_ready=1. On req_valid, latch store, funct3, addr, and wdata, then check the request:
  - Illegal: funct3 ∈ {011, 110, 111}; for stores, also funct3[2]=1.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠00.
  - Error → RESP with resp_error=1, no memory access. Otherwise → REQ.
- REQ: mem_valid=1; mem_addr, mem_wdata, and mem_wstrb are held stable from the latched request.
  - On mem_ready, capture mem_rdata and go to RESP.
  - Otherwise, increment the wait counter. When it reaches TIMEOUT_CYCLES, go to RESP with resp_error=1. mem_valid deasserts the following cycle; this abort is the only legal early drop of mem_valid.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Store lanes, with o = addr[1:0]:
  - SB: wdata = {4{wdata[7:0]}}, wstrb = 4'b0001 << o.
  - SH: wdata = {2{wdata[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata unchanged, wstrb = 1111.
- Load extraction: shift the captured word right by 8·o. B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- resp_rdata is forced to 0 for stores and errors.
- All address/data arithmetic is 32-bit unsigned, with no wrap checks. Address 0xFFFFFFFC word access is legal.

## Timing
- Reset values: state IDLE, req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, resp_valid=0, resp_rdata=0, resp_error=0, wait counter=0.
- Reset mid-transaction: mem_valid falls asynchronously and the response is lost. This is legal.
- mem_valid, mem_wstrb, resp_valid, resp_rdata, and resp_error are registered. req_ready is decoded from state.
- Accept at edge N → mem_valid high in cycle N+1. If mem_ready is high in N+1, resp_valid is high in N+2. Minimum latency is 2 cycles accept-to-response, then IDLE at N+3.
- Error at accept: resp_valid in N+1, never mem_valid.
- Each cycle of mem_ready low adds one cycle. A timeout yields resp_valid TIMEOUT_CYCLES+1 cycles after mem_valid rises.
- req_valid while req_ready=0 is ignored; the core must hold it.
- mem_ready while mem_valid=0 is ignored.
- Back-to-back accesses: a new accept is possible in the cycle after resp_valid (throughput 1 access per 3 cycles minimum).
- The wait counter clears on every accept.

## Test plan
- LW addr 0x0000_0104, mem_ready immediate, rdata 0xDEADBEEF → mem_addr 0x104, wstrb 0000, resp_rdata 0xDEADBEEF, resp_valid 2 cycles after accept, error 0.
- LB / LBU addr 0x103, rdata 0x80FF_0000 → LB resp_rdata 0xFFFFFF80, LBU resp_rdata 0x00000080.
- SB addr 0x202, wdata 0x12345678 → mem_wdata 0x78787878, wstrb 0100, mem_addr 0x200. SH addr 0x202 → wdata 0x56785678, wstrb 1100.
- LW addr 0x101, and SH addr 0x3 → resp_error=1 one cycle after accept, mem_valid never asserted, resp_rdata 0.
- mem_ready held low 3 cycles then high → outputs stable throughout, resp after 5 cycles. With TIMEOUT_CYCLES=4 and mem_ready never high → resp_error=1, mem_valid drops.
- Assert reset in REQ → mem_valid 0 immediately, req_ready 1 after release, next LW completes normally.
